// File: rtl/abr_masked_add_sub_issue_ctrl.sv
// Issue/retire controller for the Boolean-masked modular add/sub datapath.
// Refreshes operand masks at accept, tracks in-flight ops in a fixed-latency
// valid/tag pipe, and returns results through a credit-protected FWFT buffer.
// The add/sub mode is frozen while anything is in flight because the
// datapath cannot stall.
module abr_masked_add_sub_issue_ctrl #(
  parameter int WIDTH      = 23,
  parameter int DP_LATENCY = 27,
  parameter int DEPTH      = 4,
  parameter int TAG_W      = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      zeroize,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sub,
  input  logic [TAG_W-1:0]          in_tag,
  input  logic [1:0][WIDTH-1:0]     in_opa_masked,
  input  logic [1:0][WIDTH-1:0]     in_opb_masked,
  input  logic [2*WIDTH-1:0]        rnd_refresh,
  output logic                      dp_sub_o,
  output logic [1:0][WIDTH-1:0]     dp_opa_o,
  output logic [1:0][WIDTH-1:0]     dp_opb_o,
  input  logic [1:0][WIDTH-1:0]     dp_res_i,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [TAG_W-1:0]          out_tag,
  output logic [1:0][WIDTH-1:0]     out_res_masked
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                           r_state;
  logic                             r_live;
  logic [DP_LATENCY:0]              r_vld_pipe;
  logic [DP_LATENCY:0][TAG_W-1:0]   r_tag_pipe;
  logic [CNT_W-1:0]                 r_cnt;
  logic [CNT_W-1:0]                 r_bcnt;
  logic [PTR_W-1:0]                 r_wptr;
  logic [PTR_W-1:0]                 r_rptr;
  logic [DEPTH-1:0][TAG_W-1:0]      r_buf_tag;
  logic [DEPTH-1:0][1:0][WIDTH-1:0] r_buf_res;

  logic w_mode_ok, w_accept, w_pop, w_push, w_pipe_empty;
  logic [WIDTH-1:0] w_ra, w_rb;

  assign w_ra         = rnd_refresh[WIDTH-1:0];
  assign w_rb         = rnd_refresh[2*WIDTH-1:WIDTH];
  assign w_pipe_empty = ~|r_vld_pipe;
  // IDLE takes either mode; RUN only the mode already loaded; DRAIN nothing.
  assign w_mode_ok    = (r_state == IDLE) | ((r_state == RUN) & (in_sub == dp_sub_o));
  assign in_ready     = r_live & ~zeroize & (r_cnt < CNT_W'(DEPTH)) & w_mode_ok;
  assign w_accept     = in_valid & in_ready;
  assign out_valid    = (r_bcnt != '0);
  assign w_pop        = out_valid & out_ready;
  assign w_push       = r_vld_pipe[DP_LATENCY];
  // Idle buffer slots are not exposed: outputs read zero when nothing is valid.
  assign out_tag        = out_valid ? r_buf_tag[r_rptr] : '0;
  assign out_res_masked = out_valid ? r_buf_res[r_rptr] : '0;

  // Mode FSM: loads the datapath mode on the first accept and drains before a switch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      dp_sub_o <= 1'b0;
      r_live   <= 1'b0;
    end else if (zeroize) begin
      r_state  <= IDLE;
      dp_sub_o <= 1'b0;
      r_live   <= 1'b1;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        IDLE: if (w_accept) begin
          dp_sub_o <= in_sub;
          r_state  <= RUN;
        end
        RUN: begin
          if (in_valid && (in_sub != dp_sub_o)) r_state <= DRAIN;
          else if (w_pipe_empty && !w_accept)   r_state <= IDLE;
        end
        DRAIN: if (w_pipe_empty) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Mask refresh: each share is XORed with the same random bit, never with the other share.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_opa_o <= '0;
      dp_opb_o <= '0;
    end else if (zeroize) begin
      dp_opa_o <= '0;
      dp_opb_o <= '0;
    end else if (w_accept) begin
      dp_opa_o[1] <= in_opa_masked[1] ^ w_ra;
      dp_opa_o[0] <= in_opa_masked[0] ^ w_ra;
      dp_opb_o[1] <= in_opb_masked[1] ^ w_rb;
      dp_opb_o[0] <= in_opb_masked[0] ^ w_rb;
    end
  end

  // Valid/tag pipe mirrors the datapath latency; the last stage marks dp_res_i as live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_tag_pipe <= '0;
    end else if (zeroize) begin
      r_vld_pipe <= '0;
      r_tag_pipe <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[DP_LATENCY-1:0], w_accept};
      r_tag_pipe <= {r_tag_pipe[DP_LATENCY-1:0], in_tag};
    end
  end

  // Credits cover in-flight plus buffered results so a capture always finds a free slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_cnt <= '0;
    else if (zeroize) r_cnt <= '0;
    else begin
      case ({w_accept, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Output FIFO, first-word-fall-through; push and pop may coincide even when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_bcnt    <= '0;
      r_buf_tag <= '0;
      r_buf_res <= '0;
    end else if (zeroize) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_bcnt    <= '0;
      r_buf_tag <= '0;
      r_buf_res <= '0;
    end else begin
      if (w_push) begin
        r_buf_tag[r_wptr] <= r_tag_pipe[DP_LATENCY];
        r_buf_res[r_wptr] <= dp_res_i;
        r_wptr            <= r_wptr + PTR_W'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_bcnt <= r_bcnt + CNT_W'(1);
        2'b01:   r_bcnt <= r_bcnt - CNT_W'(1);
        default: r_bcnt <= r_bcnt;
      endcase
    end
  end

endmodule
